alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 188 ++++++++++++++++++
 tb/tb_alu_mc.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU. Logic, shift and compare ops finish in one cycle;
// multiply and divide run a radix-2 shift/add or restoring loop for WIDTH cycles.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             less
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned DW  = 2 * WIDTH;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept_c, is_long_c, last_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, quick_res_c;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, mc_q;
  logic             a_neg_q, b_neg_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum_c, shl_c, diff_c;
  logic [WIDTH-1:0] hi_n_c, lo_n_c, q_c, r_c, long_res_c;
  logic [DW-1:0]    prod_c;

  // Exact signed compare via a WIDTH+1 bit two's-complement difference
  function automatic logic slt_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {a[WIDTH-1], a} + {~b[WIDTH-1], ~b} + (WIDTH+1)'(1);
    return d[WIDTH];
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign is_long_c = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
  assign last_c    = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: if (in_valid && !flush) begin
        accept_c  = 1'b1;
        state_nxt = is_long_c ? BUSY : DONE;
      end
      BUSY: if (last_c) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Iterative units work on magnitudes; signs are reapplied on the last step
  always_comb begin
    a_neg_c = A[WIDTH-1] && (alu_op == OP_MULH || alu_op == OP_MULHSU ||
                             alu_op == OP_DIV  || alu_op == OP_REM);
    b_neg_c = B[WIDTH-1] && (alu_op == OP_MULH || alu_op == OP_DIV || alu_op == OP_REM);
    a_mag_c = a_neg_c ? (~A + WIDTH'(1)) : A;
    b_mag_c = b_neg_c ? (~B + WIDTH'(1)) : B;
  end

  always_comb begin
    quick_res_c = '0;
    case (alu_op)
      OP_ADD:  quick_res_c = A + B;
      OP_SUB:  quick_res_c = A + ~B + WIDTH'(1);
      OP_AND:  quick_res_c = A & B;
      OP_OR:   quick_res_c = A | B;
      OP_XOR:  quick_res_c = A ^ B;
      OP_SLL:  quick_res_c = A << B[SHW-1:0];
      OP_SRL:  quick_res_c = A >> B[SHW-1:0];
      OP_SRA:  quick_res_c = WIDTH'($signed(A) >>> B[SHW-1:0]);
      OP_SLT:  quick_res_c = WIDTH'(slt_f(A, B));
      OP_SLTU: quick_res_c = WIDTH'(A < B);
      default: quick_res_c = '0;
    endcase
  end

  // One iteration: hi_q is the product high word / partial remainder, lo_q the multiplier / quotient
  always_comb begin
    sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    shl_c  = {hi_q, lo_q[WIDTH-1]};
    diff_c = shl_c - {1'b0, mc_q};
    if (op_q >= OP_DIV) begin
      hi_n_c = diff_c[WIDTH] ? shl_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
      lo_n_c = {lo_q[WIDTH-2:0], ~diff_c[WIDTH]};
    end else begin
      hi_n_c = sum_c[WIDTH:1];
      lo_n_c = {sum_c[0], lo_q[WIDTH-1:1]};
    end
    prod_c = {hi_n_c, lo_n_c};
    if (a_neg_q ^ b_neg_q) prod_c = ~prod_c + DW'(1);
    q_c = (a_neg_q ^ b_neg_q) ? (~lo_n_c + WIDTH'(1)) : lo_n_c;
    r_c = a_neg_q ? (~hi_n_c + WIDTH'(1)) : hi_n_c;
    long_res_c = '0;
    case (op_q)
      OP_MUL:                      long_res_c = prod_c[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: long_res_c = prod_c[DW-1:WIDTH];
      OP_DIV, OP_DIVU:             long_res_c = (b_q == '0) ? '1 : q_c;
      OP_REM, OP_REMU:             long_res_c = (b_q == '0) ? a_q : r_c;
      default:                     long_res_c = '0;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      cnt_q   <= '0;
      res     <= '0;
      zero    <= 1'b1;
      less    <= 1'b0;
    end else if (accept_c) begin
      op_q    <= alu_op;
      a_q     <= A;
      b_q     <= B;
      a_neg_q <= a_neg_c;
      b_neg_q <= b_neg_c;
      cnt_q   <= '0;
      hi_q    <= '0;
      if (alu_op >= OP_DIV) begin
        lo_q <= a_mag_c;
        mc_q <= b_mag_c;
      end else begin
        lo_q <= b_mag_c;
        mc_q <= a_mag_c;
      end
      if (!is_long_c) begin
        res  <= quick_res_c;
        zero <= (quick_res_c == '0);
        less <= slt_f(A, B);
      end
    end else if (state == BUSY && !flush) begin
      hi_q  <= hi_n_c;
      lo_q  <= lo_n_c;
      cnt_q <= cnt_q + CW'(1);
      if (last_c) begin
        res  <= long_res_c;
        zero <= (long_res_c == '0);
        less <= slt_f(a_q, b_q);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized scoreboard bench for alu_mc, reference computed with
// 64-bit integer arithmetic.
`timescale 1ns/1ps
module tb_alu_mc;
  localparam int unsigned W = 32;

  logic         clk;
  logic         cpu_rst, in_valid, in_ready, flush, out_valid, out_ready, zero, less;
  logic [4:0]   alu_op;
  logic [W-1:0] a, b, res;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         less;
    int           acc;
    int           lat;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  alu_mc #(.WIDTH(W)) dut (
    .cpu_clk(clk), .cpu_rst(cpu_rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .A(a), .B(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .zero(zero), .less(less)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] av,
                                         input logic [W-1:0] bv);
    longint sa, sbv, ua, ub, p;
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    ua  = longint'({32'd0, av});
    ub  = longint'({32'd0, bv});
    case (op)
      5'd0:  p = ua + ub;
      5'd1:  p = ua - ub;
      5'd2:  p = ua & ub;
      5'd3:  p = ua | ub;
      5'd4:  p = ua ^ ub;
      5'd5:  p = ua << bv[4:0];
      5'd6:  p = ua >> bv[4:0];
      5'd7:  p = sa >>> bv[4:0];
      5'd8:  p = (sa < sbv) ? 64'd1 : 64'd0;
      5'd9:  p = (ua < ub) ? 64'd1 : 64'd0;
      5'd10: p = sa * sbv;
      5'd11: p = (sa * sbv) >>> 32;
      5'd12: p = (sa * ub) >>> 32;
      5'd13: p = (ua * ub) >> 32;
      5'd14: p = (bv == 0) ? -64'sd1 : sa / sbv;
      5'd15: p = (bv == 0) ? -64'sd1 : ua / ub;
      5'd16: p = (bv == 0) ? ua : sa % sbv;
      5'd17: p = (bv == 0) ? ua : ua % ub;
      default: p = 0;
    endcase
    return p[31:0];
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Call aligned at posedge+1; returns at posedge+1 right after the accept edge
  task automatic issue(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit push);
    int   waited;
    exp_t e;
    waited = 0;
    while (!in_ready && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    alu_op = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op = 5'($urandom); a = 32'($urandom); b = 32'($urandom);
    if (push) begin
      e.res  = model(op, av, bv);
      e.zero = (e.res == 0);
      e.less = ($signed(av) < $signed(bv));
      e.acc  = cyc;
      e.lat  = (op >= 5'd10 && op <= 5'd17) ? W + 1 : 1;
      e.op   = op;
      e.a    = av;
      e.b    = bv;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every cycle a result is presented; pop on handoff
  initial begin
    exp_t  e;
    bit    seen;
    string tag;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!cpu_rst && out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e   = sb[0];
          tag = $sformatf("op=%0d A=%h B=%h", e.op, e.a, e.b);
          chk({"res ", tag}, 64'(res), 64'(e.res));
          chk({"zero ", tag}, 64'(zero), 64'(e.zero));
          chk({"less ", tag}, 64'(less), 64'(e.less));
          chk({"in_ready_while_done ", tag}, 64'(in_ready), 64'd0);
          if (!seen) begin
            chk({"latency ", tag}, 64'(cyc - e.acc + 1), 64'(e.lat));
            seen = 1'b1;
          end
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    alu_op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_less", 64'(less), 64'd0);
    cpu_rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases
    issue(5'd0,  32'hFFFF_FFFF, 32'h1, 1);
    issue(5'd8,  32'h8000_0000, 32'h7FFF_FFFF, 1);
    issue(5'd9,  32'h8000_0000, 32'h7FFF_FFFF, 1);
    issue(5'd7,  32'h8000_0000, 32'h0000_0024, 1);
    issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(5'd17, 32'd7, 32'd0, 1);
    issue(5'd14, 32'hFFFF_FFF9, 32'd2, 1);
    issue(5'd16, 32'hFFFF_FFF9, 32'd2, 1);
    issue(5'd14, 32'hFFFF_FFFB, 32'd0, 1);
    issue(5'd16, 32'hFFFF_FFFB, 32'd0, 1);
    issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(5'd20, 32'd3, 32'd9, 1);
    drain();

    // Result held while consumer stalls
    rdy_mode = 2;
    issue(5'd1, 32'd10, 32'd3, 1);
    repeat (6) begin @(posedge clk); #1; end
    chk("held_out_valid", 64'(out_valid), 64'd1);
    chk("held_in_ready", 64'(in_ready), 64'd0);
    rdy_mode = 0;
    drain();

    // Flush ten cycles into a DIVU
    issue(5'd15, 32'($urandom), 32'($urandom) | 32'h1, 0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (W + 4) begin @(posedge clk); #1; end
    issue(5'd0, 32'd5, 32'd6, 1);
    drain();

    // flush together with in_valid must not accept
    in_valid = 1'b1; alu_op = 5'd0; a = 32'd1; b = 32'd2; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", 64'(in_ready), 64'd1);
    repeat (3) begin @(posedge clk); #1; end

    // Reset in the middle of a divide
    issue(5'd14, 32'd100, 32'd7, 0);
    repeat (5) begin @(posedge clk); #1; end
    cpu_rst = 1'b1;
    @(posedge clk); #1;
    cpu_rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_res", 64'(res), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    chk("midrst_less", 64'(less), 64'd0);
    repeat (W + 4) begin @(posedge clk); #1; end
    issue(5'd0, 32'h1234_5678, 32'h1111_1111, 1);
    drain();

    // Random traffic with random consumer backpressure
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      issue(5'($urandom_range(0, 31)), rand_opnd(), rand_opnd(), 1);
    end
    rdy_mode = 0;
    drain();
    repeat (4) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
